// File: rtl/shared_mem_pkg.sv
// Shared types and address helpers for the CPU memory responder.
// State encoding, port identifiers, word-index and range-check functions.
package shared_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Helpers work on a widened address so any ADDR_W up to 64 fits
  localparam int unsigned CALC_W = 64;

  function automatic logic [CALC_W-1:0] word_index(input logic [CALC_W-1:0] addr);
    return addr >> 2;
  endfunction

  function automatic logic addr_error(input logic [CALC_W-1:0] addr,
                                      input int unsigned     depth_words);
    return (addr[1:0] != 2'b00) || (addr >= (CALC_W'(depth_words) << 2));
  endfunction

endpackage

// File: rtl/shared_mem_responder_arbiter.sv
// Fixed-priority arbiter (data port first) with a starvation guard that
// hands the slot to the fetch port after STARVE_MAX back-to-back data grants.
module mem_arbiter
  import shared_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       grant_en,
  output logic [1:0] grant
);

  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CNT_W-1:0] starve_cnt;
  logic             fetch_wins;

  assign fetch_wins = i_req && (!d_req || (starve_cnt == CNT_W'(STARVE_MAX)));

  always_comb begin
    grant         = '0;
    grant[PORT_I] = grant_en && fetch_wins;
    grant[PORT_D] = grant_en && d_req && !fetch_wins;
  end

  // Counts only data grants taken while fetch is waiting; never exceeds STARVE_MAX
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!i_req || grant[PORT_I]) begin
      starve_cnt <= '0;
    end else if (grant[PORT_D]) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shared_mem_responder.sv
// Responder for the CPU fetch and data ports sharing one single-ported array.
// Arbitrates, applies a fixed access latency and range/alignment checks.
module shared_mem_responder
  import shared_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  lat_cnt;
  logic              cap_port;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_we;
  logic [DATA_W-1:0] cap_wdata;

  logic [1:0]        grant;
  logic              grant_en;
  logic              accept;
  logic              acc_err;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic              resp_i, resp_d;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Ready is only offered from IDLE and never while reset is held
  assign grant_en = reset_n && (state_q == IDLE);
  assign accept   = |grant;

  mem_arbiter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .i_req   (i_req),
    .d_req   (d_req),
    .grant_en(grant_en),
    .grant   (grant)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (lat_cnt == LAST_CNT) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lat_cnt   <= '0;
      cap_port  <= PORT_I;
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        cap_port  <= grant[PORT_D] ? PORT_D : PORT_I;
        cap_addr  <= grant[PORT_D] ? d_addr : i_addr;
        cap_we    <= grant[PORT_D] && d_we;
        cap_wdata <= d_wdata;
        lat_cnt   <= '0;
      end else if (state_q == WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
    end
  end

  assign acc_err = addr_error(CALC_W'(cap_addr), DEPTH_WORDS);
  assign idx     = IDX_W'(word_index(CALC_W'(cap_addr)));
  assign rd_word = mem[idx];

  assign resp_i = (state_q == RESP) && (cap_port == PORT_I);
  assign resp_d = (state_q == RESP) && (cap_port == PORT_D);

  // Write lands on the RESP edge so a reset during WAIT/RESP discards it
  always_ff @(posedge clock) begin
    if (reset_n && resp_d && cap_we && !acc_err) mem[idx] <= cap_wdata;
  end

  assign i_ready  = grant[PORT_I];
  assign d_ready  = grant[PORT_D];
  assign i_rvalid = resp_i;
  assign i_rdata  = (resp_i && !acc_err) ? rd_word : '0;
  assign d_rvalid = resp_d;
  assign d_err    = resp_d && acc_err;
  assign d_rdata  = (resp_d && !cap_we && !acc_err) ? rd_word : '0;
  assign busy     = (state_q != IDLE);

endmodule
